uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue_if.sv | 26 ++
 rtl/uart_tx_queue.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_queue.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_queue_if.sv
// Byte-queue side and serial-line side of the queued UART transmitter.
// The master drives enqueue requests; the slave (the transmitter) reports line and queue status.
interface uart_tx_queue_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

    logic               transmit;
    logic [7:0]         tx_byte;
    logic               tx;
    logic               is_transmitting;
    logic               full;
    logic               empty;
    logic [LEVEL_W-1:0] level;
    logic               overflow;

    modport master (
        output transmit, tx_byte,
        input  tx, is_transmitting, full, empty, level, overflow
    );

    modport slave (
        input  transmit, tx_byte,
        output tx, is_transmitting, full, empty, level, overflow
    );
endinterface

// File: rtl/uart_tx_queue.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames from queued bytes are sent back to back.
// The serial line is registered and the next frame starts on the final stop-bit cycle.
module uart_tx_queue #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_queue_if.slave bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);
    localparam int TIMER_W = $clog2(CLKS_PER_BIT);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
            $error("uart_tx_queue: CLKS_PER_BIT must be in 2..65535");
        end
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_queue: FIFO_DEPTH must be a power of two in 2..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ---------------- byte queue ----------------
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] level_q;
    logic               overflow_q;
    logic               full_w;
    logic               empty_w;
    logic               enq;
    logic               deq;

    assign full_w  = (level_q == LEVEL_FULL);
    assign empty_w = (level_q == '0);
    assign enq     = bus.transmit && !full_w;

    // NOTE: the storage array carries no reset; level and the pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= bus.tx_byte;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   level_q <= level_q + LEVEL_W'(1);
                2'b01:   level_q <= level_q - LEVEL_W'(1);
                default: level_q <= level_q;
            endcase
            overflow_q <= bus.transmit && full_w;
        end
    end

    // ---------------- serial framer ----------------
    state_t             state_q;
    state_t             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic [2:0]         bit_idx_q;
    logic [2:0]         bit_idx_d;
    logic [2:0]         bit_idx_inc;
    logic [7:0]         shift_q;
    logic [7:0]         shift_d;
    logic               tx_q;
    logic               tx_d;
    logic               timer_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // tx_d is the line level for the cycle after this edge, so it follows the state being entered.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can hold a value and infer a latch.
        state_d     = state_q;
        timer_d     = timer_q + TIMER_W'(1);
        bit_idx_d   = bit_idx_q;
        bit_idx_inc = bit_idx_q + 3'd1;
        shift_d     = shift_q;
        tx_d        = tx_q;
        deq         = 1'b0;
        timer_done  = (timer_q == TIMER_LAST);

        case (state_q)
            IDLE: begin
                timer_d = '0;
                tx_d    = 1'b1;
                if (!empty_w) begin
                    deq     = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (timer_done) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_inc;
                        tx_d      = shift_q[bit_idx_inc];
                    end
                end
            end
            STOP: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (!empty_w) begin
                        deq     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign bus.tx              = tx_q;
    assign bus.is_transmitting = (state_q != IDLE);
    assign bus.full            = full_w;
    assign bus.empty           = empty_w;
    assign bus.level           = level_q;
    assign bus.overflow        = overflow_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a queue/frame-offset model checked every cycle,
// a passive UART receiver, and directed scenarios with hand-computed expectations.
module tb_uart_tx_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_queue_if #(.FIFO_DEPTH(DEPTH)) bus0 ();
    uart_tx_queue_if #(.FIFO_DEPTH(DEPTH)) bus1 ();

    uart_tx_queue #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    uart_tx_queue #(.CLKS_PER_BIT(2), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cbit(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    // which: 0 tx, 1 is_transmitting, 2 full, 3 empty, 4 level, 5 overflow
    function automatic logic [31:0] dut_out(input int d, input int which);
        logic [31:0] v;
        v = '0;
        case (which)
            0: v = 32'(d == 0 ? bus0.tx              : bus1.tx);
            1: v = 32'(d == 0 ? bus0.is_transmitting : bus1.is_transmitting);
            2: v = 32'(d == 0 ? bus0.full            : bus1.full);
            3: v = 32'(d == 0 ? bus0.empty           : bus1.empty);
            4: v = 32'(d == 0 ? bus0.level           : bus1.level);
            default: v = 32'(d == 0 ? bus0.overflow  : bus1.overflow);
        endcase
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    // Queue held as a packed shift list (head in the low byte); a frame is a busy flag
    // plus the cycle offset within the 10-bit frame.
    logic [127:0] m_q    [2];
    int           m_n    [2];
    logic         m_busy [2];
    int           m_off  [2];
    logic [7:0]   m_cur  [2];
    logic         m_ovf  [2];

    always @(posedge clk) begin : model
        logic [127:0] q;
        int           n;
        int           pre;
        int           off;
        logic         busy;
        logic         ovf;
        logic         tr;
        logic [7:0]   cur;
        logic [7:0]   nb;
        for (int d = 0; d < 2; d++) begin
            q    = m_q[d];
            n    = m_n[d];
            off  = m_off[d];
            busy = m_busy[d];
            cur  = m_cur[d];
            ovf  = 1'b0;
            tr   = (d == 0) ? bus0.transmit : bus1.transmit;
            nb   = (d == 0) ? bus0.tx_byte  : bus1.tx_byte;
            if (rst) begin
                q    = '0;
                n    = 0;
                off  = 0;
                busy = 1'b0;
            end else begin
                pre = n;
                if (!busy || off == 10 * cbit(d) - 1) begin
                    if (pre > 0) begin
                        cur  = q[7:0];
                        q    = q >> 8;
                        n    = n - 1;
                        busy = 1'b1;
                    end else begin
                        busy = 1'b0;
                    end
                    off = 0;
                end else begin
                    off = off + 1;
                end
                if (tr) begin
                    if (pre == DEPTH) begin
                        ovf = 1'b1;
                    end else begin
                        q[8*n +: 8] = nb;
                        n = n + 1;
                    end
                end
            end
            m_q[d]    <= q;
            m_n[d]    <= n;
            m_off[d]  <= off;
            m_busy[d] <= busy;
            m_cur[d]  <= cur;
            m_ovf[d]  <= ovf;
        end
    end

    function automatic logic exp_tx(input int d);
        int b;
        if (!m_busy[d]) return 1'b1;
        b = m_off[d] / cbit(d);
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[d][b-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin : compare
        for (int d = 0; d < 2; d++) begin
            check($sformatf("model tx dut%0d", d),       dut_out(d, 0), 32'(exp_tx(d)));
            check($sformatf("model busy dut%0d", d),     dut_out(d, 1), 32'(m_busy[d]));
            check($sformatf("model full dut%0d", d),     dut_out(d, 2), 32'(m_n[d] == DEPTH));
            check($sformatf("model empty dut%0d", d),    dut_out(d, 3), 32'(m_n[d] == 0));
            check($sformatf("model level dut%0d", d),    dut_out(d, 4), 32'(m_n[d]));
            check($sformatf("model overflow dut%0d", d), dut_out(d, 5), 32'(m_ovf[d]));
        end
    end

    // ---------------- passive receiver on dut0 (4 clocks per bit) ----------------
    logic       rx_act = 1'b0;
    int         rx_t   = 0;
    logic [7:0] rx_sh  = '0;
    logic [7:0] rx_bytes [32];
    int         rx_n   = 0;

    always @(negedge clk) begin : receiver
        if (!bus0.is_transmitting) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (bus0.tx == 1'b0) begin
                rx_act <= 1'b1;
                rx_t   <= 0;
            end
        end else begin
            rx_t <= rx_t + 1;
            if ((rx_t + 1) % 4 == 0) begin
                if ((rx_t + 1) / 4 <= 8) begin
                    rx_sh[(rx_t + 1) / 4 - 1] <= bus0.tx;
                end else begin
                    if (rx_n < 32) rx_bytes[rx_n] <= rx_sh;
                    rx_n   <= rx_n + 1;
                    rx_act <= 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic txlog [256];
    int   busy_cnt;
    int   peak_lvl;
    logic first_empty;

    task automatic set_in(input int d, input logic t, input logic [7:0] b);
        if (d == 0) begin
            bus0.transmit = t;
            bus0.tx_byte  = b;
        end else begin
            bus1.transmit = t;
            bus1.tx_byte  = b;
        end
    endtask

    // Called at a negedge; presents one byte per cycle, then drops transmit at the following negedge.
    task automatic drive(input int d, input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            set_in(d, 1'b1, bytes[8*i +: 8]);
        end
        @(negedge clk);
        set_in(d, 1'b0, 8'h00);
    endtask

    // Logs tx over one contiguous busy stretch, starting with the current negedge.
    task automatic capture(input int d, input int max_cycles);
        logic done;
        logic busy;
        done        = 1'b0;
        busy_cnt    = 0;
        peak_lvl    = 0;
        first_empty = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            busy = dut_out(d, 1) != 0;
            if (busy) begin
                if (busy_cnt == 0) first_empty = dut_out(d, 3) != 0;
                if (busy_cnt < 256) txlog[busy_cnt] = dut_out(d, 0) != 0;
                busy_cnt++;
            end else if (busy_cnt > 0) begin
                done = 1'b1;
                break;
            end
            if (int'(dut_out(d, 4)) > peak_lvl) peak_lvl = int'(dut_out(d, 4));
            @(negedge clk);
        end
        check("capture ended", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input int d, input int max_cycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (dut_out(d, 1) == 0 && dut_out(d, 3) != 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("wait idle", 32'(done), 32'd1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [0:9]    pat10;
        logic [0:19]   pat20;
        logic [103:0]  exp_rx;
        int            seen;

        rst = 1'b1;
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        check("reset tx",       dut_out(0, 0), 32'd1);
        check("reset busy",     dut_out(0, 1), 32'd0);
        check("reset full",     dut_out(0, 2), 32'd0);
        check("reset empty",    dut_out(0, 3), 32'd1);
        check("reset level",    dut_out(0, 4), 32'd0);
        check("reset overflow", dut_out(0, 5), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single byte 0xA5
        drive(0, 64'hA5, 1);
        check("a5 level before dequeue", dut_out(0, 4), 32'd1);
        capture(0, 200);
        check("a5 frame cycles", 32'(busy_cnt), 32'd40);
        check("a5 empty after dequeue", 32'(first_empty), 32'd1);
        pat10 = 10'b0101001011;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("a5 bit%0d", k), 32'(txlog[4*k + 2]), 32'(pat10[k]));
        end

        // back-to-back 0x00 then 0xFF
        @(negedge clk);
        drive(0, 64'hFF00, 2);
        capture(0, 300);
        check("b2b contiguous cycles", 32'(busy_cnt), 32'd80);
        check("b2b peak level", 32'(peak_lvl), 32'd1);
        pat20 = 20'b0000000001_0111111111;
        for (int k = 0; k < 20; k++) begin
            check($sformatf("b2b bit%0d", k), 32'(txlog[4*k + 2]), 32'(pat20[k]));
        end

        // overflow: six bytes into a four-deep queue
        @(negedge clk);
        drive(0, 64'h06_05_04_03_02_01, 6);
        check("ovf pulse", dut_out(0, 5), 32'd1);
        check("ovf full",  dut_out(0, 2), 32'd1);
        check("ovf level", dut_out(0, 4), 32'd4);
        @(negedge clk);
        check("ovf pulse ends", dut_out(0, 5), 32'd0);
        wait_idle(0, 400);

        // full queue, enqueue attempted on the final stop-bit cycle
        @(negedge clk);
        drive(0, 64'h55_44_33_22_11, 5);
        repeat (36) @(negedge clk);
        set_in(0, 1'b1, 8'h66);
        @(negedge clk);
        set_in(0, 1'b0, 8'h00);
        check("simul overflow", dut_out(0, 5), 32'd1);
        check("simul level",    dut_out(0, 4), 32'd3);
        check("simul full",     dut_out(0, 2), 32'd0);
        check("simul busy",     dut_out(0, 1), 32'd1);
        wait_idle(0, 400);
        repeat (2) @(negedge clk);

        exp_rx = 104'h55_44_33_22_11_05_04_03_02_01_FF_00_A5;
        check("rx byte count", 32'(rx_n), 32'd13);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("rx byte%0d", i), 32'(rx_bytes[i]), 32'(exp_rx[8*i +: 8]));
        end

        // reset during data bit 3 with two bytes queued; transmit during reset is ignored
        drive(0, 64'h96_3C_C3, 3);
        repeat (15) @(negedge clk);
        check("pre-reset level", dut_out(0, 4), 32'd2);
        rst = 1'b1;
        set_in(0, 1'b1, 8'h77);
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 1'b0, 8'h00);
        check("mid reset tx",    dut_out(0, 0), 32'd1);
        check("mid reset busy",  dut_out(0, 1), 32'd0);
        check("mid reset level", dut_out(0, 4), 32'd0);
        check("mid reset empty", dut_out(0, 3), 32'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (dut_out(0, 1) != 0) seen++;
        end
        check("no frame after reset", 32'(seen), 32'd0);
        check("rx count after reset", 32'(rx_n), 32'd13);

        // two clocks per bit, 0x55
        drive(1, 64'h55, 1);
        capture(1, 100);
        check("div2 frame cycles", 32'(busy_cnt), 32'd20);
        pat10 = 10'b0101010101;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("div2 bit%0d", k), 32'(txlog[2*k + 1]), 32'(pat10[k]));
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
